// File: rtl/hazard_scoreboard.sv
// Hazard-detection and forwarding scoreboard at the ID/EX boundary.
// Tracks in-flight register writers and decides stall and forward selects.
module hazard_scoreboard #(
    parameter int  REG_AW   = 5,
    parameter int  DEPTH    = 4,
    parameter int  ALU_LAT  = 1,
    parameter int  LOAD_LAT = 2,
    parameter int  LONG_LAT = 3,
    parameter int  CNT_W    = 16,
    localparam int FW       = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic [REG_AW-1:0] issue_rs_i,
    input  logic [REG_AW-1:0] issue_rt_i,
    input  logic              issue_uses_rs_i,
    input  logic              issue_uses_rt_i,
    input  logic              issue_wr_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    input  logic [1:0]        issue_class_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              issue_fire_o,
    output logic [FW-1:0]     fwd_a_o,
    output logic [FW-1:0]     fwd_b_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    if (!(ALU_LAT >= 1 && ALU_LAT <= LOAD_LAT &&
          LOAD_LAT <= LONG_LAT && LONG_LAT <= DEPTH - 1)) begin : g_bad_lat
        $error("hazard_scoreboard: illegal latency parameters");
    end

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic [FW-1:0]     lat;
    } slot_t;

    slot_t             slot_q [1:DEPTH];
    slot_t             slot_d [1:DEPTH];

    logic [FW-1:0]     fwd_a_q, fwd_a_d;
    logic [FW-1:0]     fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [FW-1:0]     cls_lat;
    logic              live_a, live_b;
    logic [DEPTH:1]    hit_a, hit_b;
    logic [DEPTH:1]    vld_vec;

    logic              any_a, any_b;
    logic [FW-1:0]     pos_a, pos_b;
    logic [FW-1:0]     lat_a, lat_b;
    logic              haz_a, haz_b;
    logic              cand;

    // A source only participates when it is read and is not r0.
    assign live_a = issue_uses_rs_i & (issue_rs_i != '0);
    assign live_b = issue_uses_rt_i & (issue_rt_i != '0);

    for (genvar k = 1; k <= DEPTH; k++) begin : g_match
        assign vld_vec[k] = slot_q[k].vld;
        assign hit_a[k]   = live_a & slot_q[k].vld &
                            (slot_q[k].rd == issue_rs_i);
        assign hit_b[k]   = live_b & slot_q[k].vld &
                            (slot_q[k].rd == issue_rt_i);
    end

    // Result latency of the issuing instruction; class 3 behaves as ALU.
    always_comb begin
        cls_lat = FW'(ALU_LAT);
        case (issue_class_i)
            2'd1:    cls_lat = FW'(LOAD_LAT);
            2'd2:    cls_lat = FW'(LONG_LAT);
            default: cls_lat = FW'(ALU_LAT);
        endcase
    end

    // Youngest-match search: scanning old to young lets the youngest win.
    always_comb begin
        any_a = 1'b0;
        pos_a = '0;
        lat_a = '0;
        any_b = 1'b0;
        pos_b = '0;
        lat_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit_a[k]) begin
                any_a = 1'b1;
                pos_a = FW'(k);
                lat_a = slot_q[k].lat;
            end
            if (hit_b[k]) begin
                any_b = 1'b1;
                pos_b = FW'(k);
                lat_b = slot_q[k].lat;
            end
        end
    end

    // A producer in slot k has its result ready once k reaches its latency.
    assign haz_a = any_a & (pos_a < lat_a);
    assign haz_b = any_b & (pos_b < lat_b);

    assign cand         = issue_valid_i & ~flush_i;
    assign stall_o      = cand & (haz_a | haz_b);
    assign issue_fire_o = cand & ~stall_o;

    // Forward selects for the next EX instruction; retired slot needs none.
    always_comb begin
        fwd_a_d = '0;
        fwd_b_d = '0;
        if (issue_fire_o) begin
            if (any_a && (pos_a < FW'(DEPTH))) begin
                fwd_a_d = pos_a + FW'(1);
            end
            if (any_b && (pos_b < FW'(DEPTH))) begin
                fwd_b_d = pos_b + FW'(1);
            end
        end
    end

    // Slot 1 takes the accepted writer (or a bubble); the rest shift down.
    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            slot_d[k] = '0;
        end
        if (issue_fire_o && issue_wr_i && (issue_rd_i != '0)) begin
            slot_d[1].vld = 1'b1;
            slot_d[1].rd  = issue_rd_i;
            slot_d[1].lat = cls_lat;
        end
        for (int k = 2; k <= DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_o && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k <= DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign busy_o      = |vld_vec;
    assign stall_cnt_o = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding scoreboard for the in-order pipeline. It sits at the ID→EX boundary and tracks every in-flight register write across DEPTH post-issue pipeline slots. Each slot records the writer's latency class: single-cycle ALU, load, or a long multi-cycle op. From this it decides per issue attempt whether to stall (and insert a bubble) and, for each source operand, which pipeline stage supplies the forwarded value when the instruction executes.

## Interface
Parameters:
- REG_AW, 5: register address width.
- DEPTH, 4: tracked slots after issue; slot 1 = EX, slot DEPTH = last stage before the register file.
- ALU_LAT, 1: result-ready latency of class 0 (ALU).
- LOAD_LAT, 2: result-ready latency of class 1 (load).
- LONG_LAT, 3: result-ready latency of class 2 (long op). Legal range: 1 ≤ ALU_LAT ≤ LOAD_LAT ≤ LONG_LAT ≤ DEPTH-1.
- CNT_W, 16: stall counter width.

Ports (FW = $clog2(DEPTH+1)):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- issue_valid_i  in  1  ID holds an instruction attempting issue.
- issue_rs_i  in  REG_AW  source A address.
- issue_rt_i  in  REG_AW  source B address.
- issue_uses_rs_i  in  1  source A is read.
- issue_uses_rt_i  in  1  source B is read.
- issue_wr_i  in  1  instruction writes a register.
- issue_rd_i  in  REG_AW  destination address.
- issue_class_i  in  2  latency class: 0 ALU, 1 load, 2 long; 3 is treated as 0.
- flush_i  in  1  discard the current issue candidate (branch/jump taken).
- stall_o  out  1  hold PC and IF/ID; combinational.
- issue_fire_o  out  1  candidate accepted this cycle; combinational.
- fwd_a_o  out  FW  source A select for the instruction now in EX: 0 = register file, k = stage k.
- fwd_b_o  out  FW  source B select, same encoding.
- busy_o  out  1  any valid slot.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

## Operation
- State: slots 1..DEPTH, each holding {valid, rd, lat}. Every cycle, slot k+1 ← slot k, and slot DEPTH retires (dropped).
- Slot 1 loads from the candidate when issue_fire_o is 1 and issue_wr_i is 1 and issue_rd_i ≠ 0. Otherwise slot 1 loads a bubble (valid=0).
- Match: a source matches slot k when all of these hold: its uses bit is set, the address is ≠ 0, slot k is valid, and slot k's rd equals the address. The youngest match (smallest k) wins. Older matches are ignored.
- Hazard: the youngest match at slot k with k < slot.lat.
- stall_o = issue_valid_i & ~flush_i & (hazard on A | hazard on B).
- issue_fire_o = issue_valid_i & ~flush_i & ~stall_o.
- Forward select: registered on each edge where issue_fire_o=1. For each source, the value is k+1 if the youngest match is at slot k and k+1 ≤ DEPTH; otherwise 0. On edges where fire=0, both selects load 0, since EX holds a bubble.
- Flush has priority over stall. Older slots are never flushed.
- The register file is write-before-read, so a producer that has retired needs no forwarding.
- stall_cnt_o increments on each cycle with stall_o=1 and holds at all-ones.
- busy_o = OR of slot valids, taken from registered state.

## Timing
- Reset (rst_i=1 at an edge): all slots invalid, fwd_a_o=fwd_b_o=0, stall_cnt_o=0, busy_o=0. With issue_valid_i=0, stall_o and issue_fire_o are both 0.
- Reset mid-operation clears all in-flight state in one edge. The next cycle sees no hazards.
- Stall duration for a consumer issued directly after a producer of latency L: L-1 cycles. ALU=0, load=1, long=2 at defaults.
- A producer issued at edge t occupies slot k during cycle t+k.
- fwd_*_o is valid in the cycle immediately after the firing edge, which is the consumer's EX cycle.
- A source matching two different slots resolves to the youngest. Both sources may match the same slot, and both selects are then equal.

## Test plan
- Reset: hold rst_i 2 cycles with random inputs → stall_o=0 (with valid=0), fwd_a_o=fwd_b_o=0, busy_o=0, stall_cnt_o=0.
- ALU→ALU: issue rd=3 class 0, then the consumer rs=3 on the next cycle → stall_o=0, fires immediately, fwd_a_o=2 in its EX cycle.
- Load-use: issue rd=5 class 1, then consumer rt=5 → stall_o=1 for one cycle, fires on the second, fwd_b_o=3, stall_cnt_o=1.
- Long op: issue rd=7 class 2, then consumer rs=7 and rt=7 → 2 stall cycles, then fwd_a_o=fwd_b_o=4, stall_cnt_o=2.
- r0 and priority: producer rd=0 then consumer rs=0 → no stall, fwd_a_o=0. Producers rd=4 twice in a row, then consumer rs=4 → fwd_a_o=2, the youngest.
- Flush and retire: flush_i=1 during a load-use stall → stall_o=0, issue_fire_o=0, slot 1 gets a bubble. A consumer issued 4 cycles after its producer → fwd 0, the register file.
